// File: rtl/cycle_update_pkg.sv
// Shared types and constants for the staged PWM cycle update buffer.
package cycle_update_pkg;

    localparam int unsigned CYCLE_W   = 13;
    localparam int unsigned DEF_DEPTH = 249;
    localparam int unsigned DEF_LANES = 1;

    typedef logic [CYCLE_W-1:0] cycle_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        WAIT_SYNC
    } state_e;

    // The index must hold idx+LANES on the final beat without wrapping.
    function automatic int unsigned idx_width(input int unsigned depth, input int unsigned lanes);
        return $clog2(depth + lanes);
    endfunction

    localparam int unsigned IDX_W = idx_width(DEF_DEPTH, DEF_LANES);

endpackage

// File: rtl/cycle_calc_lane.sv
// One clamp-and-subtract unit: raises a cycle to MIN_CYCLE and derives c-1 and c-2.
module cycle_calc_lane
    import cycle_update_pkg::*;
#(
    parameter int unsigned WIDTH     = CYCLE_W,
    parameter int unsigned MIN_CYCLE = 3
) (
    input  logic [WIDTH-1:0] cyc_in,
    output logic [WIDTH-1:0] cyc,
    output logic [WIDTH-1:0] cyc_m1,
    output logic [WIDTH-1:0] cyc_m2,
    output logic             clamp
);

    localparam logic [WIDTH-1:0] MIN_C = WIDTH'(MIN_CYCLE);

    always_comb begin
        clamp  = (cyc_in < MIN_C);
        cyc    = clamp ? MIN_C : cyc_in;
        cyc_m1 = cyc - WIDTH'(1);
        cyc_m2 = cyc - WIDTH'(2);
    end

endmodule

// File: rtl/cycle_update_buffer.sv
// Per-channel PWM cycle store: snapshot on UPDATE, sweep into a shadow bank, commit all
// channels together on the SYNC strobe.
module cycle_update_buffer
    import cycle_update_pkg::*;
#(
    parameter int unsigned WIDTH         = CYCLE_W,
    parameter int unsigned DEPTH         = 249,
    parameter int unsigned LANES         = 1,
    parameter int unsigned MIN_CYCLE     = 3,
    parameter int unsigned DEFAULT_CYCLE = 4096
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [DEPTH-1:0][WIDTH-1:0] CYCLE,
    input  logic                        UPDATE,
    input  logic                        SYNC,
    output logic [DEPTH-1:0][WIDTH-1:0] CYCLE_OUT,
    output logic [DEPTH-1:0][WIDTH-1:0] CYCLE_M1,
    output logic [DEPTH-1:0][WIDTH-1:0] CYCLE_M2,
    output logic                        BUSY,
    output logic                        PENDING,
    output logic                        CLAMPED
);

    localparam int unsigned      IW      = idx_width(DEPTH, LANES);
    localparam logic [IW-1:0]    LANES_I = IW'(LANES);
    localparam logic [WIDTH-1:0] DEF_C   = WIDTH'(DEFAULT_CYCLE);
    localparam logic [WIDTH-1:0] DEF_M1  = WIDTH'(DEFAULT_CYCLE - 1);
    localparam logic [WIDTH-1:0] DEF_M2  = WIDTH'(DEFAULT_CYCLE - 2);
    localparam logic [WIDTH-1:0] MIN_C   = WIDTH'(MIN_CYCLE);

    if (MIN_CYCLE < 2) begin : g_chk_min
        $error("cycle_update_buffer: MIN_CYCLE must be at least 2");
    end
    if (DEFAULT_CYCLE < MIN_CYCLE || DEFAULT_CYCLE >= (1 << WIDTH)) begin : g_chk_def
        $error("cycle_update_buffer: DEFAULT_CYCLE out of range");
    end
    if (LANES < 1 || LANES > DEPTH) begin : g_chk_lanes
        $error("cycle_update_buffer: LANES must be within 1..DEPTH");
    end

    state_e                      state_q, state_d;
    logic [IW-1:0]               idx_q, idx_d;
    logic [DEPTH-1:0][WIDTH-1:0] snap_q, snap_d;
    logic [DEPTH-1:0][WIDTH-1:0] sh_q, sh_d;
    logic [DEPTH-1:0][WIDTH-1:0] sh_m1_q, sh_m1_d;
    logic [DEPTH-1:0][WIDTH-1:0] sh_m2_q, sh_m2_d;
    logic [DEPTH-1:0][WIDTH-1:0] out_q, out_d;
    logic [DEPTH-1:0][WIDTH-1:0] out_m1_q, out_m1_d;
    logic [DEPTH-1:0][WIDTH-1:0] out_m2_q, out_m2_d;
    logic                        clamped_q, clamped_d;

    logic [LANES-1:0][IW-1:0]    lane_pos;
    logic [LANES-1:0]            lane_ok;
    logic [LANES-1:0][WIDTH-1:0] lane_in;
    logic [LANES-1:0][WIDTH-1:0] lane_c;
    logic [LANES-1:0][WIDTH-1:0] lane_m1;
    logic [LANES-1:0][WIDTH-1:0] lane_m2;
    logic [LANES-1:0]            lane_clamp;
    logic                        last_beat;

    // Lanes past the end of the bank on the final beat stay inert.
    always_comb begin
        lane_pos = '0;
        lane_ok  = '0;
        lane_in  = '0;
        for (int unsigned j = 0; j < LANES; j++) begin
            lane_pos[j] = idx_q + IW'(j);
            lane_ok[j]  = (32'(lane_pos[j]) < DEPTH);
            lane_in[j]  = lane_ok[j] ? snap_q[lane_pos[j]] : MIN_C;
        end
    end

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        cycle_calc_lane #(
            .WIDTH    (WIDTH),
            .MIN_CYCLE(MIN_CYCLE)
        ) u_lane (
            .cyc_in(lane_in[j]),
            .cyc   (lane_c[j]),
            .cyc_m1(lane_m1[j]),
            .cyc_m2(lane_m2[j]),
            .clamp (lane_clamp[j])
        );
    end

    assign last_beat = (32'(idx_q) + LANES >= DEPTH);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (UPDATE) state_d = SCAN;
            SCAN:      if (UPDATE) state_d = SCAN;
                       else if (last_beat) state_d = WAIT_SYNC;
            WAIT_SYNC: if (UPDATE) state_d = SCAN;
                       else if (SYNC) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        BUSY    = (state_q == SCAN);
        PENDING = (state_q == WAIT_SYNC);
    end

    // Commit and a fresh snapshot can share one clock: the pending set is copied out
    // before the shadow bank is overwritten by the new sweep.
    always_comb begin
        snap_d    = snap_q;
        idx_d     = idx_q;
        sh_d      = sh_q;
        sh_m1_d   = sh_m1_q;
        sh_m2_d   = sh_m2_q;
        out_d     = out_q;
        out_m1_d  = out_m1_q;
        out_m2_d  = out_m2_q;
        clamped_d = clamped_q;

        if (state_q == WAIT_SYNC && SYNC) begin
            out_d    = sh_q;
            out_m1_d = sh_m1_q;
            out_m2_d = sh_m2_q;
        end

        if (UPDATE) begin
            snap_d    = CYCLE;
            idx_d     = '0;
            clamped_d = 1'b0;
        end else if (state_q == SCAN) begin
            for (int unsigned j = 0; j < LANES; j++) begin
                if (lane_ok[j]) begin
                    sh_d[lane_pos[j]]    = lane_c[j];
                    sh_m1_d[lane_pos[j]] = lane_m1[j];
                    sh_m2_d[lane_pos[j]] = lane_m2[j];
                    clamped_d            = clamped_d | lane_clamp[j];
                end
            end
            idx_d = idx_q + LANES_I;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            idx_q     <= '0;
            snap_q    <= {DEPTH{DEF_C}};
            sh_q      <= {DEPTH{DEF_C}};
            sh_m1_q   <= {DEPTH{DEF_M1}};
            sh_m2_q   <= {DEPTH{DEF_M2}};
            out_q     <= {DEPTH{DEF_C}};
            out_m1_q  <= {DEPTH{DEF_M1}};
            out_m2_q  <= {DEPTH{DEF_M2}};
            clamped_q <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            snap_q    <= snap_d;
            sh_q      <= sh_d;
            sh_m1_q   <= sh_m1_d;
            sh_m2_q   <= sh_m2_d;
            out_q     <= out_d;
            out_m1_q  <= out_m1_d;
            out_m2_q  <= out_m2_d;
            clamped_q <= clamped_d;
        end
    end

    assign CYCLE_OUT = out_q;
    assign CYCLE_M1  = out_m1_q;
    assign CYCLE_M2  = out_m2_q;
    assign CLAMPED   = clamped_q;

endmodule

// File: tb/tb_cycle_update_buffer.sv
// Scoreboard bench for cycle_update_buffer with LANES=1 and LANES=4 instances.
module tb_cycle_update_buffer;
    import cycle_update_pkg::*;

    localparam int unsigned DEPTH = 249;

    typedef logic [DEPTH-1:0][CYCLE_W-1:0] bank_t;
    typedef struct {
        bank_t c;
        bit    clamp;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst, upd, syn;
    bank_t cyc, co, cm1, cm2;
    logic  busy, pend, clmp;
    logic  rst4, upd4, syn4;
    bank_t cyc4, co4, cm14, cm24;
    logic  busy4, pend4, clmp4;

    int    checks = 0;
    int    errors = 0;
    exp_t  q[$];
    exp_t  q4[$];
    bank_t act, act4, def_bank, nb;
    exp_t  e;
    int    n;

    always #5 clk = ~clk;

    cycle_update_buffer #(
        .WIDTH(13), .DEPTH(DEPTH), .LANES(1), .MIN_CYCLE(3), .DEFAULT_CYCLE(4096)
    ) dut (
        .CLK(clk), .RST(rst), .CYCLE(cyc), .UPDATE(upd), .SYNC(syn),
        .CYCLE_OUT(co), .CYCLE_M1(cm1), .CYCLE_M2(cm2),
        .BUSY(busy), .PENDING(pend), .CLAMPED(clmp)
    );

    cycle_update_buffer #(
        .WIDTH(13), .DEPTH(DEPTH), .LANES(4), .MIN_CYCLE(3), .DEFAULT_CYCLE(4096)
    ) dut4 (
        .CLK(clk), .RST(rst4), .CYCLE(cyc4), .UPDATE(upd4), .SYNC(syn4),
        .CYCLE_OUT(co4), .CYCLE_M1(cm14), .CYCLE_M2(cm24),
        .BUSY(busy4), .PENDING(pend4), .CLAMPED(clmp4)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_bank(input string tag, input bank_t o, input bank_t m1,
                              input bank_t m2, input bank_t ex);
        for (int i = 0; i < int'(DEPTH); i++) begin
            check($sformatf("%s.out[%0d]", tag, i), int'(o[i]), int'(ex[i]));
            check($sformatf("%s.m1[%0d]", tag, i), int'(m1[i]), int'(ex[i]) - 1);
            check($sformatf("%s.m2[%0d]", tag, i), int'(m2[i]), int'(ex[i]) - 2);
        end
    endtask

    function automatic exp_t model(input bank_t c);
        exp_t r;
        r.clamp = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (int'(c[i]) < 3) begin
                r.c[i]  = 13'd3;
                r.clamp = 1'b1;
            end else begin
                r.c[i] = c[i];
            end
        end
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse(input bit u, input bit s, input bank_t c);
        cyc = c; upd = u; syn = s;
        tick();
        upd = 1'b0; syn = 1'b0;
    endtask

    task automatic pulse4(input bit u, input bit s, input bank_t c);
        cyc4 = c; upd4 = u; syn4 = s;
        tick();
        upd4 = 1'b0; syn4 = 1'b0;
    endtask

    task automatic count_busy(input bit which, output int beats);
        beats = 0;
        while ((which ? busy4 : busy) && beats < 1000) begin
            beats++;
            tick();
        end
    endtask

    task automatic pop_active(input string tag);
        check({tag, ".queue_nonempty"}, q.size(), q.size() > 0 ? q.size() : 1);
        if (q.size() > 0) begin
            e   = q.pop_front();
            act = e.c;
        end
    endtask

    task automatic commit(input string tag);
        pulse(1'b0, 1'b1, cyc);
        pop_active(tag);
        check_bank(tag, co, cm1, cm2, act);
        check({tag, ".pending"}, int'(pend), 0);
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) def_bank[i] = 13'd4096;
        rst = 1'b1; upd = 1'b0; syn = 1'b0; cyc = '0;
        rst4 = 1'b1; upd4 = 1'b0; syn4 = 1'b0; cyc4 = '0;
        tick();
        repeat (2) tick();
        rst = 1'b0; rst4 = 1'b0;
        act = def_bank; act4 = def_bank;

        check_bank("reset", co, cm1, cm2, act);
        check("reset.busy", int'(busy), 0);
        check("reset.pending", int'(pend), 0);
        check("reset.clamped", int'(clmp), 0);
        check_bank("reset4", co4, cm14, cm24, act4);
        check("reset4.busy", int'(busy4), 0);

        pulse(1'b0, 1'b1, cyc);
        check_bank("idle_sync", co, cm1, cm2, act);
        check("idle_sync.pending", int'(pend), 0);

        // basic commit
        for (int i = 0; i < int'(DEPTH); i++) nb[i] = 13'(2000 + i);
        q.push_back(model(nb));
        pulse(1'b1, 1'b0, nb);
        check("basic.busy", int'(busy), 1);
        count_busy(1'b0, n);
        check("basic.beats", n, 249);
        check("basic.pending", int'(pend), 1);
        check_bank("basic_hold", co, cm1, cm2, act);
        commit("basic");
        check("basic.ch10", int'(co[10]), 2010);
        check("basic.ch10_m2", int'(cm2[10]), 2008);

        // clamp
        for (int i = 0; i < int'(DEPTH); i++) nb[i] = 13'd3000;
        nb[5] = 13'd1; nb[7] = 13'd0;
        q.push_back(model(nb));
        pulse(1'b1, 1'b0, nb);
        count_busy(1'b0, n);
        check("clamp.beats", n, 249);
        check("clamp.pend_flag", int'(clmp), int'(q[0].clamp));
        commit("clamp");
        check("clamp.ch5", int'(co[5]), 3);
        check("clamp.ch7_m2", int'(cm2[7]), 1);
        check("clamp.hold", int'(clmp), 1);

        for (int i = 0; i < int'(DEPTH); i++) nb[i] = (i % 2 == 0) ? 13'd3 : 13'd8191;
        q.push_back(model(nb));
        pulse(1'b1, 1'b0, nb);
        check("noclamp.cleared", int'(clmp), 0);
        count_busy(1'b0, n);
        check("noclamp.beats", n, 249);
        check("noclamp.flag", int'(clmp), int'(q[0].clamp));
        commit("noclamp");

        // restart mid-sweep, with a SYNC that must be ignored
        for (int i = 0; i < int'(DEPTH); i++) nb[i] = 13'(5000 + i);
        q.push_back(model(nb));
        pulse(1'b1, 1'b0, nb);
        repeat (100) tick();
        check("restart.busy", int'(busy), 1);
        for (int i = 0; i < int'(DEPTH); i++) nb[i] = 13'(6000 - i);
        void'(q.pop_back());
        q.push_back(model(nb));
        pulse(1'b1, 1'b1, nb);
        check_bank("restart_hold", co, cm1, cm2, act);
        count_busy(1'b0, n);
        check("restart.beats", n, 249);
        check("restart.pending", int'(pend), 1);
        commit("restart");

        // UPDATE and SYNC together while a set is pending
        for (int i = 0; i < int'(DEPTH); i++) nb[i] = 13'(1000 + 2 * i);
        q.push_back(model(nb));
        pulse(1'b1, 1'b0, nb);
        count_busy(1'b0, n);
        check("simA.beats", n, 249);
        check("simA.pending", int'(pend), 1);
        for (int i = 0; i < int'(DEPTH); i++) nb[i] = 13'(7000 + i);
        pop_active("simA");
        q.push_back(model(nb));
        pulse(1'b1, 1'b1, nb);
        check_bank("simA", co, cm1, cm2, act);
        check("simB.busy", int'(busy), 1);
        count_busy(1'b0, n);
        check("simB.beats", n, 249);
        commit("simB");

        // four lanes
        for (int i = 0; i < int'(DEPTH); i++) nb[i] = 13'(100 + 7 * i);
        q4.push_back(model(nb));
        pulse4(1'b1, 1'b0, nb);
        count_busy(1'b1, n);
        check("l4.beats", n, 63);
        check("l4.pending", int'(pend4), 1);
        pulse4(1'b0, 1'b1, cyc4);
        check("l4.queue_nonempty", q4.size(), 1);
        if (q4.size() > 0) begin
            e    = q4.pop_front();
            act4 = e.c;
        end
        check_bank("l4", co4, cm14, cm24, act4);
        check("l4.ch248", int'(co4[248]), 1836);

        for (int i = 0; i < int'(DEPTH); i++) nb[i] = 13'(8000 - i);
        q4.push_back(model(nb));
        pulse4(1'b1, 1'b0, nb);
        repeat (20) tick();
        rst4 = 1'b1;
        repeat (2) tick();
        rst4 = 1'b0;
        q4.delete();
        act4 = def_bank;
        check_bank("l4_rst", co4, cm14, cm24, act4);
        check("l4_rst.busy", int'(busy4), 0);
        check("l4_rst.pending", int'(pend4), 0);
        check("l4_rst.clamped", int'(clmp4), 0);
        pulse4(1'b0, 1'b1, cyc4);
        check_bank("l4_rst_sync", co4, cm14, cm24, act4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cycle_update_buffer.md
# cycle_update_buffer

Per-channel PWM cycle store that replaces the free-running `cycle - 1` / `cycle - 2` precompute with a staged, commit-on-sync update. A new cycle set is snapshotted on request and swept through LANES clamp/subtract units per clock into a shadow bank. The shadow bank is copied to the active outputs only on the next SYNC strobe, so all DEPTH channels switch period on the same clock. It sits between the controller register map and the per-transducer PWM generators.

## Interface
- WIDTH, 13: bit width of a cycle value.
- DEPTH, 249: number of channels.
- LANES, 1: channels processed per clock during a sweep; 1 ≤ LANES ≤ DEPTH.
- MIN_CYCLE, 3: smallest legal cycle; must be ≥ 2 (elaboration-time check).
- DEFAULT_CYCLE, 4096: cycle loaded at reset; must satisfy MIN_CYCLE ≤ DEFAULT_CYCLE < 2^WIDTH.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- CYCLE  in  [WIDTH-1:0][DEPTH]  requested cycles; sampled only in the clock where UPDATE is high.
- UPDATE  in  1  single-cycle request to snapshot CYCLE and start a sweep.
- SYNC  in  1  single-cycle commit strobe, the period-boundary sync pulse.
- CYCLE_OUT  out  [WIDTH-1:0][DEPTH]  active (clamped) cycle per channel.
- CYCLE_M1  out  [WIDTH-1:0][DEPTH]  CYCLE_OUT − 1.
- CYCLE_M2  out  [WIDTH-1:0][DEPTH]  CYCLE_OUT − 2.
- BUSY  out  1  high while a sweep is in progress.
- PENDING  out  1  high while a completed shadow bank waits for SYNC.
- CLAMPED  out  1  high if any channel of the current or pending set was raised to MIN_CYCLE.

## Operation
- FSM states: IDLE, SCAN, WAIT_SYNC. BUSY = (state == SCAN). PENDING = (state == WAIT_SYNC).
- UPDATE in any state:
  - Snapshot CYCLE into the input bank.
  - Set idx = 0 and clear CLAMPED.
  - Enter SCAN.
  - An in-progress sweep or pending set is discarded.
- SCAN beat: for each lane j with idx+j < DEPTH:
  - c = max(snap[idx+j], MIN_CYCLE).
  - shadow[idx+j] ← c, shadow_m1 ← c−1, shadow_m2 ← c−2.
  - CLAMPED |= (snap < MIN_CYCLE).
  - Lanes with idx+j ≥ DEPTH are inert.
  - idx += LANES.
- Last beat (idx+LANES ≥ DEPTH) → WAIT_SYNC.
- WAIT_SYNC with SYNC high → copy all three shadow arrays to the outputs in one clock, then go to IDLE.
- SYNC in IDLE or SCAN is ignored; it is not remembered.
- UPDATE and SYNC in the same clock while in WAIT_SYNC: commit the pending set first, and the new snapshot/sweep starts the same clock (→ SCAN).
- Arithmetic: all values are WIDTH bits. MIN_CYCLE ≥ 2 guarantees no underflow. Inputs are never truncated or widened.
- Reset:
  - CYCLE_OUT = DEFAULT_CYCLE, CYCLE_M1 = DEFAULT_CYCLE−1, CYCLE_M2 = DEFAULT_CYCLE−2.
  - Shadow and snapshot banks are loaded with the same values.
  - BUSY = PENDING = CLAMPED = 0, state IDLE, idx = 0.
  - Reset mid-sweep or mid-pending discards everything; RST has priority over UPDATE and SYNC.

## Timing
- N = ceil(DEPTH/LANES) sweep beats. Default N = 249.
- UPDATE sampled at edge e0 → BUSY = 1 from e0 to e0+N. PENDING = 1 after edge e0+N.
- SYNC sampled at edge e with PENDING = 1 → new CYCLE_OUT/M1/M2 visible after edge e, PENDING = 0 after edge e.
- All outputs are registered; there is no combinational path from inputs to outputs.
- The minimum UPDATE-to-commit time is N+1 clocks.
- CLAMPED is final when PENDING rises and holds until the next UPDATE or RST.

## Structure
- Shared package `cycle_update_pkg`:
  - state enum (IDLE, SCAN, WAIT_SYNC);
  - `cycle_t` typedef (logic [WIDTH-1:0]);
  - idx width constant $clog2(DEPTH+LANES).
- Sub-module `cycle_calc_lane`: one clamp-and-subtract unit. Inputs are a cycle and the MIN_CYCLE parameter; outputs are c, c−1, c−2 and a clamp flag. It is instantiated LANES times under a generate loop.
- The top module holds the FSM, idx counter, snapshot, shadow and active banks.

## Test plan
- Reset: assert RST for 2 clocks → all CYCLE_OUT = 4096, M1 = 4095, M2 = 4094, BUSY/PENDING/CLAMPED = 0.
- Basic commit:
  - CYCLE[i] = 2000+i, pulse UPDATE → BUSY for 249 clocks, then PENDING.
  - Outputs unchanged until SYNC; one clock after SYNC, CYCLE_OUT[10] = 2010, M1 = 2009, M2 = 2008 on all channels simultaneously.
- Clamp: CYCLE[5] = 1, CYCLE[7] = 0, others 3000 → after commit CYCLE_OUT[5] = CYCLE_OUT[7] = 3, M2 = 1, CLAMPED = 1. A following UPDATE with all values ≥ 3 → CLAMPED = 0.
- Restart and ignored SYNC:
  - UPDATE, then at beat 100 UPDATE again with new values and SYNC → sweep restarts from idx 0, SYNC has no effect.
  - Only the second set commits.
- Simultaneous UPDATE+SYNC in WAIT_SYNC (set A pending, set B applied) → A visible next clock, BUSY = 1, B commits on a later SYNC.
- LANES = 4, DEPTH = 249: sweep takes 63 clocks; channel 248 is correct and there are no writes beyond DEPTH. RST mid-sweep → outputs hold the default values.
